// File: rtl/seq_stage_sequencer.sv
// Multi-cycle stage sequencer for the sequential RISC-V core: one-hot stage enables, wait-states,
// halt handling and cycle/retired counters. Define SEQ_STEP_EN to add single-step PAUSE support.
module seq_stage_sequencer #(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned FETCH_WAIT = 0,
   parameter int unsigned MEM_WAIT   = 0,
   parameter int unsigned MAX_INSTR  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_mem,
   input  logic             halt_req,
`ifdef SEQ_STEP_EN
   input  logic             step_mode,
   input  logic             step,
`endif
   output logic             fetch_en,
   output logic             decode_en,
   output logic             exec_en,
   output logic             mem_en,
   output logic             wb_en,
   output logic             pc_we,
   output logic             busy,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt, StPause
   } state_e;

   localparam logic [3:0]       FetchWait = 4'(FETCH_WAIT);
   localparam logic [3:0]       MemWait   = 4'(MEM_WAIT);
   localparam logic [CNT_W-1:0] MaxInstr  = CNT_W'(MAX_INSTR);
   localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

   state_e           state_q, state_d;
   logic [3:0]       wait_q, wait_d;
   logic             mem_q, mem_d;
   logic             halt_q, halt_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] instr_q, instr_d;
   logic [CNT_W-1:0] instr_inc;
   logic             halt_hit;
   logic             fetch_q, fetch_d, decode_q, decode_d, exec_q, exec_d;
   logic             memen_q, memen_d, wb_q, wb_d, busy_q, busy_d, halted_q, halted_d;

   assign instr_inc = instr_q + CntOne;
   // Budget compare uses the wrapped count, so a wrapped counter can still hit MAX_INSTR.
   assign halt_hit  = halt_q || ((MAX_INSTR != 0) && (instr_inc == MaxInstr));

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      mem_d   = mem_q;
      halt_d  = halt_q;
      instr_d = instr_q;
      cycle_d = busy_q ? cycle_q + CntOne : cycle_q;

      case (state_q)
         StIdle: begin
            wait_d = 4'd0;
            if (start) state_d = StFetch;
         end
         StFetch: begin
            if (wait_q == FetchWait) begin
               wait_d  = 4'd0;
               state_d = StDecode;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         StDecode: begin
            mem_d   = is_mem;
            halt_d  = halt_req;
            state_d = StExec;
         end
         StExec: begin
            wait_d  = 4'd0;
            state_d = mem_q ? StMem : StWb;
         end
         StMem: begin
            if (wait_q == MemWait) begin
               wait_d  = 4'd0;
               state_d = StWb;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         StWb: begin
            instr_d = instr_inc;
            wait_d  = 4'd0;
            if (halt_hit) state_d = StHalt;
`ifdef SEQ_STEP_EN
            else if (step_mode) state_d = StPause;
`endif
            else state_d = StFetch;
         end
         StHalt: state_d = StHalt;
`ifdef SEQ_STEP_EN
         StPause: begin
            wait_d = 4'd0;
            if (step || !step_mode) state_d = StFetch;
         end
`endif
         default: state_d = StIdle;
      endcase

      // Output flops are loaded from the next state so they track state_q exactly.
      fetch_d  = (state_d == StFetch);
      decode_d = (state_d == StDecode);
      exec_d   = (state_d == StExec);
      memen_d  = (state_d == StMem);
      wb_d     = (state_d == StWb);
      halted_d = (state_d == StHalt);
      busy_d   = fetch_d | decode_d | exec_d | memen_d | wb_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         wait_q   <= 4'd0;
         mem_q    <= 1'b0;
         halt_q   <= 1'b0;
         cycle_q  <= '0;
         instr_q  <= '0;
         fetch_q  <= 1'b0;
         decode_q <= 1'b0;
         exec_q   <= 1'b0;
         memen_q  <= 1'b0;
         wb_q     <= 1'b0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         mem_q    <= mem_d;
         halt_q   <= halt_d;
         cycle_q  <= cycle_d;
         instr_q  <= instr_d;
         fetch_q  <= fetch_d;
         decode_q <= decode_d;
         exec_q   <= exec_d;
         memen_q  <= memen_d;
         wb_q     <= wb_d;
         busy_q   <= busy_d;
         halted_q <= halted_d;
      end
   end

   assign fetch_en  = fetch_q;
   assign decode_en = decode_q;
   assign exec_en   = exec_q;
   assign mem_en    = memen_q;
   assign wb_en     = wb_q;
   assign pc_we     = wb_q;
   assign busy      = busy_q;
   assign halted    = halted_q;
   assign cycle_cnt = cycle_q;
   assign instr_cnt = instr_q;

endmodule
